// File: rtl/dmem_wait.sv
// dmem_wait: word-organised data memory with programmable wait states and a
// req/ready/done handshake. Supports little-endian byte loads/stores.
// Optional fault checking (out-of-range / misaligned word) is compiled in
// with the macro DMEM_WAIT_ERR_CHECK_EN.
//
// Handshake: a request is accepted on a rising edge where ready=1 and req=1.
// The request fields are latched at accept and the live inputs are ignored
// afterwards. done pulses for one cycle LATENCY+1 cycles after accept. rd and
// err are valid while done=1. ready stays low from accept through the done
// cycle. A req presented while ready=0 is ignored.
module dmem_wait #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        ready,
    output logic        done,
    output logic [31:0] rd,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, byte_q;
    logic [31:0] a_q, wd_q;
    logic [31:0] rd_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    // Operands of the array access. With zero latency the access happens on
    // the accept edge itself, so the live inputs are used in IDLE.
    logic          acc_we, acc_byte;
    logic [31:0]   acc_a, acc_wd;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          fault;
    logic          access_go;
    logic [31:0]   word_rd;
    logic [31:0]   load_data;
    logic          unused_addr;

    // Select live or latched request fields and decode index, lane and fault.
    always_comb begin
        acc_we   = we_q;
        acc_byte = byte_q;
        acc_a    = a_q;
        acc_wd   = wd_q;
        if (state_q == IDLE) begin
            acc_we   = we;
            acc_byte = byte_op;
            acc_a    = a;
            acc_wd   = wd;
        end
        idx  = acc_a[AW+1:2];
        lane = acc_a[1:0];
`ifdef DMEM_WAIT_ERR_CHECK_EN
        fault = (|acc_a[31:AW+2]) | (~acc_byte & (|acc_a[1:0]));
`else
        fault = 1'b0;
`endif
        word_rd   = mem[idx];
        load_data = 32'd0;
        if (!fault) begin
            load_data = acc_byte ? {24'd0, word_rd[8*lane +: 8]} : word_rd;
        end
    end

    // Upper address bits only matter when fault checking is compiled in.
    assign unused_addr = &{1'b0, acc_a[31:AW+2]};

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The array is touched only on the edge that enters RESP, never under reset.
    assign access_go = reset && (state_q != RESP) && (state_d == RESP);

    // Control state, latched request and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            a_q     <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                we_q   <= we;
                byte_q <= byte_op;
                a_q    <= a;
                wd_q   <= wd;
            end
            if (access_go) begin
                err_q <= fault;
                if (!acc_we) begin
                    rd_q <= load_data;
                end
            end
        end
    end

    // Array write: whole word, or one byte lane for STRB; faulted stores drop.
    always_ff @(posedge clk) begin
        if (access_go && acc_we && !fault) begin
            if (acc_byte) begin
                mem[idx][8*lane +: 8] <= acc_wd[7:0];
            end else begin
                mem[idx] <= acc_wd;
            end
        end
    end

    assign rd          = rd_q;
    assign err         = done & err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Self-checking bench for dmem_wait: directed cases, randomized traffic
// against a word-array reference model, and a LATENCY sweep on extra
// instances with req held high. Honours DMEM_WAIT_ERR_CHECK_EN.
module tb_dmem_wait;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0, byte_op = 1'b0;
  logic [31:0] a = 32'd0, wd = 32'd0;
  logic        ready, done, err;
  logic [31:0] rd;
  logic [1:0]  dbg_state;

  dmem_wait #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byte_op(byte_op),
    .a(a), .wd(wd), .ready(ready), .done(done), .rd(rd), .err(err),
    .dbg_state_o(dbg_state)
  );

  // Sweep instances: LATENCY 0, 1, 15, stores with req held high.
  logic        sw_reset = 1'b0;
  logic        sw_req = 1'b0;
  logic [2:0]  sw_ready, sw_done, sw_err;
  logic [31:0] sw_rd [3];
  logic [1:0]  sw_dbg [3];

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sw
    dmem_wait #(.DEPTH(DEPTH), .LATENCY((g == 0) ? 0 : (g == 1) ? 1 : 15)) u_sw (
      .clk(clk), .reset(sw_reset), .req(sw_req), .we(1'b1), .byte_op(1'b0),
      .a(32'h0000_0040), .wd(32'h1234_5678), .ready(sw_ready[g]),
      .done(sw_done[g]), .rd(sw_rd[g]), .err(sw_err[g]), .dbg_state_o(sw_dbg[g])
    );
  end

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fault(input logic b, input logic [31:0] addr);
`ifdef DMEM_WAIT_ERR_CHECK_EN
    return (addr >= 32'(DEPTH * 4)) || (!b && addr[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic do_access(input logic w, input logic b, input logic [31:0] addr,
                           input logic [31:0] data);
    int n;
    int idx;
    int lane;
    logic f;
    logic [31:0] exp_rd;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", 32'(n < 50), 32'd1);
    req = 1'b1; we = w; byte_op = b; a = addr; wd = data;
    f    = model_fault(b, addr);
    idx  = int'(addr >> 2) % DEPTH;
    lane = int'(addr & 32'd3);
    exp_rd = 32'd0;
    if (!f) exp_rd = b ? ((mem_m[idx] >> (8 * lane)) & 32'hff) : mem_m[idx];
    if (w && !f) begin
      if (b) mem_m[idx][8*lane +: 8] = data[7:0];
      else   mem_m[idx] = data;
    end
    if (!w) exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); byte_op = 1'($urandom); a = $urandom; wd = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 40);
    check("latency", 32'(n), 32'(LAT + 1));
    check("err", 32'(err), 32'(f));
    if (!w) begin
      exp_rd = exp_q.pop_front();
      check("rd", rd, exp_rd);
    end
    @(negedge clk);
    check("ready_after", 32'(ready), 32'd1);
    check("done_single", 32'(done), 32'd0);
    if (!w) check("rd_hold", rd, exp_rd);
  endtask

  // Watch for any done pulse over a window; expects none.
  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] old30;

    // Reset check
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("sw_rst_ready", 32'(sw_ready), 32'h7);

    // Word store then load
    do_access(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b0, 32'h10, 32'h0);

    // Fill the whole array so later loads are defined
    for (int i = 0; i < DEPTH; i++) do_access(1'b1, 1'b0, 32'(i * 4), $urandom);

    // Byte lanes
    do_access(1'b1, 1'b0, 32'h20, 32'h1122_3344);
    do_access(1'b1, 1'b1, 32'h22, 32'h0000_00AA);
    do_access(1'b0, 1'b0, 32'h20, 32'h0);
    check("byte_lane_word", mem_m[8], 32'h11AA_3344);
    do_access(1'b0, 1'b1, 32'h23, 32'h0);

    // Reset during WAIT aborts a store
    do_access(1'b1, 1'b0, 32'h30, 32'hCAFE_0030);
    old30 = mem_m[12];
    req = 1'b1; we = 1'b1; byte_op = 1'b0; a = 32'h30; wd = 32'h5555_AAAA;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("in_wait_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_ready", 32'(ready), 32'd1);
    expect_no_done("abort_no_done", LAT + 3);
    do_access(1'b0, 1'b0, 32'h30, 32'h0);
    check("abort_mem", mem_m[12], old30);

    // Reset in the same cycle as req drops the request
    req = 1'b1; we = 1'b1; byte_op = 1'b0; a = 32'h30; wd = 32'h0BAD_0BAD;
    reset = 1'b0;
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    expect_no_done("drop_no_done", LAT + 3);
    do_access(1'b0, 1'b0, 32'h30, 32'h0);

    // Store followed immediately by load to the same address
    do_access(1'b1, 1'b0, 32'h44, 32'h0F0F_1234);
    do_access(1'b0, 1'b0, 32'h44, 32'h0);

`ifdef DMEM_WAIT_ERR_CHECK_EN
    do_access(1'b1, 1'b0, 32'h100, 32'h7777_7777);
    do_access(1'b0, 1'b0, 32'h000, 32'h0);
    do_access(1'b0, 1'b0, 32'h006, 32'h0);
`else
    do_access(1'b1, 1'b0, 32'h104, 32'h6666_0104);
    do_access(1'b0, 1'b0, 32'h004, 32'h0);
    check("wrap_data", mem_m[1], 32'h6666_0104);
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 7) == 0) ra = $urandom;
      do_access(1'($urandom), 1'($urandom), ra, $urandom);
    end

    // LATENCY sweep with req held high
    begin
      int last [3];
      int rcnt [3];
      int ndone [3];
      for (int g = 0; g < 3; g++) begin
        last[g] = -1; rcnt[g] = 0; ndone[g] = 0;
      end
      sw_reset = 1'b1;
      sw_req   = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
          if (sw_done[g] === 1'b1) begin
            check("sweep_ready_in_resp", 32'(sw_ready[g]), 32'd0);
            if (last[g] >= 0) begin
              check("sweep_gap", 32'(cyc - last[g]), 32'(lat_of(g) + 2));
              check("sweep_ready_cycles", 32'(rcnt[g]), 32'd1);
            end
            check("sweep_err", 32'(sw_err[g]), 32'd0);
            last[g] = cyc;
            rcnt[g] = 0;
            ndone[g]++;
          end else if (sw_ready[g] === 1'b1) begin
            rcnt[g]++;
          end
        end
      end
      for (int g = 0; g < 3; g++) check("sweep_count", 32'(ndone[g] >= 3), 32'd1);
      sw_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
